// File: rtl/fifo_sync_prog.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_prog
// Description : Single-clock FIFO of arbitrary depth. It has a selectable
//               FWFT or registered read mode, programmable almost-full and
//               almost-empty thresholds, an occupancy count with a peak
//               watermark, synchronous flush, and sticky overflow/underflow
//               flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_prog #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1),
  parameter bit FWFT       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  input  logic [CNT_W-1:0]  af_level,
  input  logic [CNT_W-1:0]  ae_level,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  max_count,
  input  logic              flush,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
);

  localparam int                 c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [CNT_W-1:0]   c_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_max_count;
  logic               r_full;
  logic               r_empty;
  logic               r_almost_full;
  logic               r_almost_empty;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_wr_en;
  logic               w_rd_en;
  logic [CNT_W-1:0]   w_count_next;

  // Accept decisions use only the registered flags, so a push while full is
  // refused even when a pop is accepted in the same cycle.
  assign w_wr_en = push && !r_full  && !flush;
  assign w_rd_en = pop  && !r_empty && !flush;

  // Next occupancy. A simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else if (w_wr_en && !w_rd_en) begin
      w_count_next = r_count + c_CNT_ONE;
    end else if (w_rd_en && !w_wr_en) begin
      w_count_next = r_count - c_CNT_ONE;
    end
  end

  // Storage array. It has no reset, and a location is written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers wrap explicitly at FIFO_DEPTH-1, so any depth is supported.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Count and status flags. The flags are computed from the next count, so
  // they always agree with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_next;
      r_full         <= (w_count_next == c_DEPTH);
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= af_level);
      r_almost_empty <= (w_count_next <= ae_level);
    end
  end

  // Sticky error flags and the peak watermark. A new error event takes
  // priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_max_count <= '0;
    end else begin
      r_overflow  <= (push && r_full  && !flush) || (r_overflow  && !err_clr);
      r_underflow <= (pop  && r_empty && !flush) || (r_underflow && !err_clr);
      if (err_clr || (w_count_next > r_max_count)) begin
        r_max_count <= w_count_next;
      end
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // The head word is presented combinationally. It is forced to zero while
      // empty, so the output matches its reset value.
      assign data_out   = r_empty ? '0 : r_mem[r_rd_ptr];
      assign data_valid = !r_empty;
    end else begin : g_reg_read
      logic [DATA_W-1:0] r_data_out;
      logic              r_data_valid;

      // Registered read. The strobe is high for one cycle after each accepted pop.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data_out   <= '0;
          r_data_valid <= 1'b0;
        end else if (w_rd_en) begin
          r_data_out   <= r_mem[r_rd_ptr];
          r_data_valid <= 1'b1;
        end else begin
          r_data_valid <= 1'b0;
        end
      end

      assign data_out   = r_data_out;
      assign data_valid = r_data_valid;
    end
  endgenerate

  assign count        = r_count;
  assign max_count    = r_max_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_prog
// Description : Scoreboard bench for fifo_sync_prog. It runs one FWFT instance
//               (depth 6) and one registered-read instance (depth 5) from
//               shared stimulus, and checks each against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_prog;

  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          push    = 1'b0;
  logic          pop     = 1'b0;
  logic          flush   = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] din     = '0;
  logic [CW-1:0] af_lvl  = 3'd5;
  logic [CW-1:0] ae_lvl  = 3'd1;
  logic [DW-1:0] dseq    = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int D = (k == 0) ? 6 : 5;
    localparam bit F = (k == 0);

    logic [DW-1:0] dout;
    logic          dval, full, empty, af, ae, ovf, udf;
    logic [CW-1:0] cnt, mx;

    fifo_sync_prog #(.DATA_W(DW), .FIFO_DEPTH(D), .CNT_W(CW), .FWFT(F)) dut (
      .clk(clk), .rst(rst), .push(push), .data_in(din), .pop(pop),
      .data_out(dout), .data_valid(dval), .full(full), .empty(empty),
      .almost_full(af), .almost_empty(ae), .af_level(af_lvl), .ae_level(ae_lvl),
      .count(cnt), .max_count(mx), .flush(flush), .err_clr(err_clr),
      .overflow(ovf), .underflow(udf)
    );

    logic [DW-1:0] q[$];
    logic [DW-1:0] sb[$];
    int            m_max = 0;
    bit            m_ovf, m_udf, m_af, m_dv, live;
    bit            m_ae = 1'b1;

    // Reference model: the FIFO contents as a queue, updated with the inputs of each edge
    always @(posedge clk) begin
      bit            wr, rd;
      logic [DW-1:0] w;
      live = 1'b1;
      if (rst) begin
        q.delete(); sb.delete();
        m_max = 0; m_ovf = 0; m_udf = 0; m_af = 0; m_ae = 1; m_dv = 0;
      end else begin
        wr    = push && (q.size() < D) && !flush;
        rd    = pop && (q.size() > 0) && !flush;
        m_ovf = (push && (q.size() == D) && !flush) || (m_ovf && !err_clr);
        m_udf = (pop && (q.size() == 0) && !flush) || (m_udf && !err_clr);
        m_dv  = 1'b0;
        if (flush) begin
          q.delete();
        end else begin
          if (rd) begin
            w = q.pop_front();
            if (!F) begin
              sb.push_back(w);
              m_dv = 1'b1;
            end
          end
          if (wr) q.push_back(din);
        end
        if (err_clr || (q.size() > m_max)) m_max = q.size();
        m_af = (q.size() >= int'(af_lvl));
        m_ae = (q.size() <= int'(ae_lvl));
      end
    end

    // Monitor: compare the flags each cycle, and compare data whenever the DUT presents it
    always @(negedge clk) begin
      if (live) begin
        chk($sformatf("i%0d.count", k), 32'(cnt), 32'(q.size()));
        chk($sformatf("i%0d.full", k), 32'(full), 32'(q.size() == D));
        chk($sformatf("i%0d.empty", k), 32'(empty), 32'(q.size() == 0));
        chk($sformatf("i%0d.almost_full", k), 32'(af), 32'(m_af));
        chk($sformatf("i%0d.almost_empty", k), 32'(ae), 32'(m_ae));
        chk($sformatf("i%0d.overflow", k), 32'(ovf), 32'(m_ovf));
        chk($sformatf("i%0d.underflow", k), 32'(udf), 32'(m_udf));
        chk($sformatf("i%0d.max_count", k), 32'(mx), 32'(m_max));
        if (F) begin
          chk($sformatf("i%0d.data_valid", k), 32'(dval), 32'(q.size() != 0));
          if (dval && (q.size() > 0)) chk($sformatf("i%0d.data_out", k), dout, q[0]);
        end else begin
          chk($sformatf("i%0d.data_valid", k), 32'(dval), 32'(m_dv));
          if (dval) begin
            if (sb.size() > 0) chk($sformatf("i%0d.data_out", k), dout, sb.pop_front());
            else chk($sformatf("i%0d.data_valid_extra", k), 32'(dval), 32'd0);
          end
        end
      end
    end
  end

  task automatic step(input bit p, input bit o, input bit f, input bit e);
    push = p; pop = o; flush = f; err_clr = e;
    if (p) begin
      din  = dseq;
      dseq = dseq + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    rst = 1'b1;
    repeat (2) step(0, 0, 0, 0);
    rst = 1'b0;

    // Fill past full (overflow), drain past empty (underflow), then clear
    dseq = 32'h10;
    repeat (7) step(1, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0);
    step(0, 0, 0, 1);

    // Sustained push+pop at count 3 across the pointer wrap
    repeat (3) step(1, 0, 0, 0);
    repeat (20) step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);

    // Single word through the registered-read path, then a pop on empty
    dseq = 32'hA5;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);

    // err_clr together with push-at-full, then err_clr alone
    repeat (6) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);

    // Flush with push and pop also asserted, then threshold edge cases
    repeat (2) step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    af_lvl = 3'd0; ae_lvl = 3'd7;
    repeat (2) step(1, 0, 0, 0);
    af_lvl = 3'd2; ae_lvl = 3'd2;
    repeat (3) step(1, 0, 0, 0);
    af_lvl = 3'd7;
    step(0, 0, 0, 0);

    // Randomised traffic with occasional flush, error clear, threshold change and reset
    repeat (3000) begin
      push    = ($urandom_range(0, 99) < 55);
      pop     = ($urandom_range(0, 99) < 50);
      flush   = ($urandom_range(0, 99) == 0);
      err_clr = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      din     = $urandom;
      if ($urandom_range(0, 19) == 0) af_lvl = CW'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) ae_lvl = CW'($urandom_range(0, 7));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_sync_prog.md
# fifo_sync_prog

Single-clock, parametrised FIFO for the on-chip pixel and command datapaths, where producer and consumer share one clock. It generalises the existing dual-clock FIFO: any depth (not only powers of two), a selectable read mode (first-word-fall-through or registered read), runtime-programmable almost-full and almost-empty thresholds, an exact occupancy count with a peak watermark, synchronous flush, and sticky overflow/underflow error flags.

## Interface
- DATA_W, 32, data word width
- FIFO_DEPTH, 16, number of entries; any integer ≥ 2
- CNT_W, $clog2(FIFO_DEPTH+1), width of the count and threshold fields
- FWFT, 1, read mode: 1 = first-word-fall-through, 0 = registered read
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- push  in  1  write request
- data_in  in  DATA_W  write data
- pop  in  1  read request
- data_out  out  DATA_W  read data
- data_valid  out  1  FWFT=1: equals !empty; FWFT=0: one-cycle strobe marking data_out as updated
- full / empty  out  1  count==FIFO_DEPTH / count==0
- almost_full  out  1  count ≥ af_level
- almost_empty  out  1  count ≤ ae_level
- af_level, ae_level  in  CNT_W  thresholds, sampled every cycle
- count  out  CNT_W  current occupancy
- max_count  out  CNT_W  peak occupancy since the last rst or err_clr
- flush  in  1  synchronous empty; overrides push and pop
- err_clr  in  1  clears overflow, underflow and max_count
- overflow / underflow  out  1  sticky error flags

## Operation
- Accept rules: wr_en = push && !full && !flush; rd_en = pop && !empty && !flush. Accept is based on the registered flags only, so a push to a full FIFO is rejected even if a pop happens in the same cycle.
- Pointers are binary and run 0..FIFO_DEPTH-1. Each wraps to 0 after FIFO_DEPTH-1, so no power-of-two masking is used.
- count_next = count + wr_en - rd_en. When both are accepted in the same cycle, count is unchanged.
- All flags are registered and computed from count_next and the current af_level/ae_level. Flags are therefore always consistent with count in the same cycle.
- FWFT=1:
  - data_out = mem[rd_ptr] (combinational) and data_valid = !empty.
  - data_out is don't-care while empty.
- FWFT=0:
  - On rd_en, data_out <= mem[rd_ptr] and data_valid <= 1 on the next edge. Otherwise data_valid <= 0 and data_out holds.
- Errors:
  - overflow is set on push && full && !flush; underflow is set on pop && empty && !flush.
  - Both are cleared by err_clr. If set and clear occur in the same cycle, set wins.
- max_count <= max(max_count, count_next) every cycle. On err_clr, max_count <= count_next.
- Flush:
  - Next edge sets pointers and count to 0, empty=1, full=0, almost_full=(0 ≥ af_level), almost_empty=1, data_valid=0.
  - Memory contents, overflow, underflow and max_count are unchanged.
- Memory has no reset. Writes to mem[wr_ptr] occur only on wr_en.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, data_valid=0, data_out=0, overflow=0, underflow=0, max_count=0. Pointers are 0.
- rst mid-operation discards all contents by the next edge; outputs take their reset values.
- Push into an empty FIFO: empty falls, and (FWFT=1) data_out is valid, one cycle after the accepting edge.
- Pop latency:
  - FWFT=1: head data is on data_out before the pop; the next word appears the cycle after the accepting edge.
  - FWFT=0: data_out and data_valid update one cycle after the accepting edge.
- Threshold inputs changed in cycle N are reflected in the almost flags after edge N.
- Full throughput is one push and one pop per cycle, sustained at any occupancy except pushes at full and pops at empty.
- Edge thresholds:
  - af_level=0: almost_full=1 from the first post-reset edge.
  - ae_level ≥ FIFO_DEPTH: almost_empty is always 1.

## Test plan
- FIFO_DEPTH=6, FWFT=1: push 0x10..0x15 on back-to-back cycles → full=1 after the 6th edge and count=6. A 7th push sets overflow=1 and does not corrupt data. Six pops return 0x10..0x15 in order, then empty=1.
- Wrap, FIFO_DEPTH=6: 20 cycles of simultaneous push and pop at count=3 → count stays 3 throughout, output order is preserved across the 5→0 pointer wrap, max_count=3.
- FWFT=0: push 0xA5, then pop → data_out=0xA5 with a one-cycle data_valid, 1 cycle after the pop edge. A pop on empty sets underflow=1 and data_valid stays 0.
- Thresholds, depth 16: af_level=12, ae_level=4; fill to 12 → almost_full rises on the 12th push edge. Then write af_level=14 → almost_full falls at the next edge.
- Flush at count=5 with push and pop asserted in the same cycle → next cycle count=0, empty=1, overflow/underflow unchanged, max_count=5.
- err_clr asserted in the same cycle as push && full → overflow stays 1. err_clr alone → overflow=0 and max_count=count.
